enemy_formation_ctrl: RTL and testbench

- Upstream controller for the enemy sprite renderers in the VGA invader game.
- Owns the formation anchor (masterPosX/masterPosY), each enemy's present bit, wave state and score. All of these feed the per-enemy sprite/collision instances.
- Consumes their combinational collision flags: kills enemies, requests bullet removal, and marches the formation left/right/down once per N frames.

---
 rtl/enemy_formation_ctrl_if.sv | 29 ++
 rtl/enemy_formation_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_enemy_formation_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_formation_ctrl_if.sv
// rtl/enemy_formation_ctrl_if.sv - formation controller signal bundle
//
// master : drives frameTick, start, collision; observes formation state.
// slave  : the controller; consumes frame/start/collision, drives anchor,
//          present bits, bulletClear, score, waveClear and invaded.
interface enemy_formation_ctrl_if #(
    parameter int NUM_ENEMY = 8
);
    logic                 frameTick;
    logic                 start;
    logic [NUM_ENEMY-1:0] collision;
    logic [9:0]           masterPosX;
    logic [9:0]           masterPosY;
    logic [NUM_ENEMY-1:0] present;
    logic                 bulletClear;
    logic [7:0]           score;
    logic                 waveClear;
    logic                 invaded;

    modport master (
        output frameTick, start, collision,
        input  masterPosX, masterPosY, present, bulletClear, score, waveClear, invaded
    );

    modport slave (
        input  frameTick, start, collision,
        output masterPosX, masterPosY, present, bulletClear, score, waveClear, invaded
    );
endinterface

// File: rtl/enemy_formation_ctrl.sv
// rtl/enemy_formation_ctrl.sv - invader formation march, hit and wave controller
//
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   bus   : enemy_formation_ctrl_if.slave
//           in : frameTick (frame pulse), start (wave start pulse),
//                collision (per-enemy hit flags)
//           out: masterPosX/masterPosY (anchor), present (alive bits),
//                bulletClear (hit accepted pulse), score (saturating kills),
//                waveClear (CLEARED), invaded (INVADED)
//
// Optional macro SPEEDUP_EN: move period shrinks by one frame per kill in
// the current wave, down to one frame.
module enemy_formation_ctrl #(
    parameter int NUM_ENEMY   = 8,
    parameter int ENEMY_PITCH = 32,
    parameter int START_X     = 16,
    parameter int START_Y     = 60,
    parameter int MIN_X       = 16,
    parameter int MAX_X       = 624,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int BOTTOM_Y    = 400,
    parameter int MOVE_FRAMES = 30
) (
    input  logic                         clk,
    input  logic                         rst_n,
    enemy_formation_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MARCH,
        S_CLEARED,
        S_INVADED
    } state_t;

    localparam logic [9:0]  START_X_V    = 10'(START_X);
    localparam logic [9:0]  START_Y_V    = 10'(START_Y);
    // Right edge test: anchor plus span of the last enemy plus one step.
    localparam logic [10:0] RIGHT_REACH  = 11'((NUM_ENEMY - 1) * ENEMY_PITCH + STEP_X);
    localparam logic [10:0] MAX_X_V      = 11'(MAX_X);
    localparam logic [10:0] LEFT_LIMIT   = 11'(MIN_X + STEP_X);
    localparam logic [10:0] STEP_X_V     = 11'(STEP_X);
    localparam logic [10:0] STEP_Y_V     = 11'(STEP_Y);
    localparam logic [10:0] BOTTOM_Y_V   = 11'(BOTTOM_Y);
    localparam logic [7:0]  MOVE_LAST    = 8'(MOVE_FRAMES - 1);
    localparam logic [NUM_ENEMY-1:0] ONE_N = NUM_ENEMY'(1);

    state_t               state_q,        state_d;
    logic [9:0]           pos_x_q,        pos_x_d;
    logic [9:0]           pos_y_q,        pos_y_d;
    logic [NUM_ENEMY-1:0] present_q,      present_d;
    logic [7:0]           score_q,        score_d;
    logic                 bullet_clear_q, bullet_clear_d;
    logic                 dir_right_q,    dir_right_d;
    logic [7:0]           frame_cnt_q,    frame_cnt_d;

    logic [NUM_ENEMY-1:0] hit_cand;
    logic [NUM_ENEMY-1:0] hit_onehot;
    logic                 hit_take;
    logic [7:0]           period_last;
    logic [10:0]          pos_x_ext;
    logic [10:0]          pos_y_desc;

`ifdef SPEEDUP_EN
    logic [7:0]           kill_cnt_q,     kill_cnt_d;

    // period - 1 = max(0, MOVE_FRAMES - 1 - kills)
    always_comb begin
        if (kill_cnt_q >= MOVE_LAST) begin
            period_last = 8'd0;
        end else begin
            period_last = MOVE_LAST - kill_cnt_q;
        end
    end
`else
    assign period_last = MOVE_LAST;
`endif

    // Lowest-index live hit; the bullet of the previous accept is still in
    // flight while bullet_clear_q is high, so nothing is taken that cycle.
    assign hit_cand   = bus.collision & present_q;
    assign hit_onehot = hit_cand & (~hit_cand + ONE_N);
    assign hit_take   = (state_q == S_MARCH) && !bullet_clear_q && (|hit_cand);
    assign pos_x_ext  = {1'b0, pos_x_q};
    assign pos_y_desc = {1'b0, pos_y_q} + STEP_Y_V;

    always_comb begin
        state_d        = state_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        present_d      = present_q;
        score_d        = score_q;
        bullet_clear_d = 1'b0;
        dir_right_d    = dir_right_q;
        frame_cnt_d    = frame_cnt_q;
`ifdef SPEEDUP_EN
        kill_cnt_d     = kill_cnt_q;
`endif
        case (state_q)
            S_MARCH: begin
                if (bus.frameTick) begin
                    // >= rather than == lets a period that shrank under the
                    // running count fire on the very next frame.
                    if (frame_cnt_q >= period_last) begin
                        frame_cnt_d = 8'd0;
                        if (dir_right_q ? (pos_x_ext + RIGHT_REACH > MAX_X_V)
                                        : (pos_x_ext < LEFT_LIMIT)) begin
                            pos_y_d     = pos_y_desc[9:0];
                            dir_right_d = !dir_right_q;
                            if (pos_y_desc >= BOTTOM_Y_V) begin
                                state_d = S_INVADED;
                            end
                        end else if (dir_right_q) begin
                            pos_x_d = pos_x_q + STEP_X_V[9:0];
                        end else begin
                            pos_x_d = pos_x_q - STEP_X_V[9:0];
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                if (hit_take) begin
                    present_d      = present_q & ~hit_onehot;
                    score_d        = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    bullet_clear_d = 1'b1;
`ifdef SPEEDUP_EN
                    kill_cnt_d     = (kill_cnt_q == 8'hFF) ? kill_cnt_q : kill_cnt_q + 8'd1;
`endif
                    // Last kill wins over a same-edge invasion.
                    if (present_d == '0) begin
                        state_d = S_CLEARED;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_d     = S_MARCH;
                    pos_x_d     = START_X_V;
                    pos_y_d     = START_Y_V;
                    present_d   = '1;
                    dir_right_d = 1'b1;
                    frame_cnt_d = 8'd0;
                    if (state_q != S_CLEARED) begin
                        score_d = 8'd0;
                    end
`ifdef SPEEDUP_EN
                    kill_cnt_d  = 8'd0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pos_x_q        <= START_X_V;
            pos_y_q        <= START_Y_V;
            present_q      <= '0;
            score_q        <= 8'd0;
            bullet_clear_q <= 1'b0;
            dir_right_q    <= 1'b1;
            frame_cnt_q    <= 8'd0;
`ifdef SPEEDUP_EN
            kill_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            present_q      <= present_d;
            score_q        <= score_d;
            bullet_clear_q <= bullet_clear_d;
            dir_right_q    <= dir_right_d;
            frame_cnt_q    <= frame_cnt_d;
`ifdef SPEEDUP_EN
            kill_cnt_q     <= kill_cnt_d;
`endif
        end
    end

    assign bus.masterPosX  = pos_x_q;
    assign bus.masterPosY  = pos_y_q;
    assign bus.present     = present_q;
    assign bus.bulletClear = bullet_clear_q;
    assign bus.score       = score_q;
    assign bus.waveClear   = (state_q == S_CLEARED);
    assign bus.invaded     = (state_q == S_INVADED);
endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// tb/tb_enemy_formation_ctrl.sv - self-checking bench for enemy_formation_ctrl
module tb_enemy_formation_ctrl;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    enemy_formation_ctrl_if #(.NUM_ENEMY(8)) bus1 ();
    enemy_formation_ctrl_if #(.NUM_ENEMY(8)) bus2 ();

    enemy_formation_ctrl dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // Low floor and one-frame period so the third descend invades quickly.
    enemy_formation_ctrl #(.BOTTOM_Y(108), .MOVE_FRAMES(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    int tests;
    int errors;
    logic [7:0] sb_q[$];
    logic prev_bc;

    typedef struct {
        string      name;
        bit         start;
        int         ticks;
        logic [7:0] coll;
        int         hold;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] p;
        logic [7:0] s;
        logic       wc;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(string n, bit st, int tk, logic [7:0] c, int h,
                                logic [9:0] x, logic [9:0] y, logic [7:0] p,
                                logic [7:0] s, logic wc);
        vec_t v;
        v.name = n; v.start = st; v.ticks = tk; v.coll = c; v.hold = h;
        v.x = x; v.y = y; v.p = p; v.s = s; v.wc = wc;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) bus1.start = 1'b1; else bus2.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus2.start = 1'b0;
    endtask

    task automatic ticks(input int d, input int n);
        if (n > 0) begin
            @(negedge clk);
            if (d == 0) bus1.frameTick = 1'b1; else bus2.frameTick = 1'b1;
            repeat (n) @(negedge clk);
            bus1.frameTick = 1'b0;
            bus2.frameTick = 1'b0;
        end
    endtask

    task automatic hold_coll(input int d, input logic [7:0] c, input int n);
        @(negedge clk);
        if (d == 0) bus1.collision = c; else bus2.collision = c;
        repeat (n) @(negedge clk);
        bus1.collision = 8'h00;
        bus2.collision = 8'h00;
    endtask

    // Expected present value after each accepted hit, lowest index first,
    // one accept opportunity every other cycle of the hold.
    task automatic push_hits(input logic [7:0] pres, input logic [7:0] c, input int n);
        logic [7:0] p;
        p = pres;
        for (int k = 0; k < (n + 1) / 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (c[i] && p[i]) begin
                    p[i] = 1'b0;
                    sb_q.push_back(p);
                    break;
                end
            end
        end
    endtask

    // Scoreboard: every bulletClear pulse must match the next queued
    // present value, and pulses are never back to back.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus1.bulletClear === 1'b1) begin
            tests++;
            if (prev_bc) begin
                errors++;
                $display("FAIL bc_adjacent: got two consecutive bulletClear pulses expected gap");
            end
            tests++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got bulletClear with present 0x%0h expected no pulse", bus1.present);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (bus1.present !== e) begin
                    errors++;
                    $display("FAIL sb_present: got 0x%0h expected 0x%0h", bus1.present, e);
                end
            end
        end
        prev_bc = (bus1.bulletClear === 1'b1);
    end

    initial begin
        tests = 0;
        errors = 0;
        prev_bc = 1'b0;
        rst_n = 1'b0;
        bus1.frameTick = 1'b0; bus1.start = 1'b0; bus1.collision = 8'h00;
        bus2.frameTick = 1'b0; bus2.start = 1'b0; bus2.collision = 8'h00;

        tbl[0]  = mk("start",        1, 0,    8'h00, 0,  16,  60, 8'hFF, 0, 0);
        tbl[1]  = mk("ticks29",      0, 29,   8'h00, 0,  16,  60, 8'hFF, 0, 0);
        tbl[2]  = mk("move1",        0, 1,    8'h00, 0,  20,  60, 8'hFF, 0, 0);
        tbl[3]  = mk("to400",        0, 2850, 8'h00, 0,  400, 60, 8'hFF, 0, 0);
        tbl[4]  = mk("descend",      0, 30,   8'h00, 0,  400, 76, 8'hFF, 0, 0);
        tbl[5]  = mk("left",         0, 30,   8'h00, 0,  396, 76, 8'hFF, 0, 0);
        tbl[6]  = mk("hit24",        0, 0,    8'h24, 4,  396, 76, 8'hDB, 2, 0);
        tbl[7]  = mk("hit_rest",     0, 0,    8'hDB, 13, 396, 76, 8'h00, 8, 1);
        tbl[8]  = mk("cleared_tick", 0, 30,   8'h00, 0,  396, 76, 8'h00, 8, 1);
        tbl[9]  = mk("restart",      1, 0,    8'h00, 0,  16,  60, 8'hFF, 8, 0);
        tbl[10] = mk("single_hit",   0, 0,    8'h80, 1,  16,  60, 8'h7F, 9, 0);
        tbl[11] = mk("ticks29b",     0, 29,   8'h00, 0,  16,  60, 8'h7F, 9, 0);

        repeat (2) @(negedge clk);
        check("rst_x", bus1.masterPosX, 16);
        check("rst_y", bus1.masterPosY, 60);
        check("rst_present", bus1.present, 8'h00);
        check("rst_score", bus1.score, 0);
        check("rst_waveclear", bus1.waveClear, 0);
        check("rst_invaded", bus1.invaded, 0);
        check("rst_bulletclear", bus1.bulletClear, 0);
        rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            logic [7:0] prev_p;
            prev_p = (r == 0) ? 8'h00 : tbl[r-1].p;
            if (tbl[r].start) pulse_start(0);
            ticks(0, tbl[r].ticks);
            if (tbl[r].hold > 0) begin
                push_hits(prev_p, tbl[r].coll, tbl[r].hold);
                hold_coll(0, tbl[r].coll, tbl[r].hold);
                @(negedge clk);
            end
            check({tbl[r].name, "_x"}, bus1.masterPosX, tbl[r].x);
            check({tbl[r].name, "_y"}, bus1.masterPosY, tbl[r].y);
            check({tbl[r].name, "_present"}, bus1.present, tbl[r].p);
            check({tbl[r].name, "_score"}, bus1.score, tbl[r].s);
            check({tbl[r].name, "_waveclear"}, bus1.waveClear, tbl[r].wc);
            check({tbl[r].name, "_invaded"}, bus1.invaded, 0);
        end

        // Hit and move on the same edge.
        sb_q.push_back(8'h7E);
        @(negedge clk);
        bus1.frameTick = 1'b1;
        bus1.collision = 8'h01;
        @(negedge clk);
        bus1.frameTick = 1'b0;
        bus1.collision = 8'h00;
        check("hitmove_x", bus1.masterPosX, 20);
        check("hitmove_present", bus1.present, 8'h7E);
        check("hitmove_score", bus1.score, 10);

        // start during MARCH is ignored.
        pulse_start(0);
        check("start_in_march_present", bus1.present, 8'h7E);
        check("start_in_march_x", bus1.masterPosX, 20);
        check("start_in_march_score", bus1.score, 10);

        // Reset mid-wave on dut1.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_x", bus1.masterPosX, 16);
        check("midrst_present", bus1.present, 8'h00);
        check("midrst_score", bus1.score, 0);

        // dut2: clear beats invasion on the same edge.
        pulse_start(1);
        hold_coll(1, 8'h01, 2);
        check("d2_first_kill_score", bus2.score, 1);
        check("d2_first_kill_present", bus2.present, 8'hFE);
        ticks(1, 290);
        check("d2_pre_x", bus2.masterPosX, 400);
        check("d2_pre_y", bus2.masterPosY, 92);
        check("d2_pre_invaded", bus2.invaded, 0);
        hold_coll(1, 8'h7E, 12);
        check("d2_last_one_present", bus2.present, 8'h80);
        @(negedge clk);
        bus2.frameTick = 1'b1;
        bus2.collision = 8'h80;
        @(negedge clk);
        bus2.frameTick = 1'b0;
        bus2.collision = 8'h00;
        check("d2_prio_waveclear", bus2.waveClear, 1);
        check("d2_prio_invaded", bus2.invaded, 0);
        check("d2_prio_y", bus2.masterPosY, 108);
        check("d2_prio_score", bus2.score, 8);
        pulse_start(1);
        check("d2_restart_score_kept", bus2.score, 8);
        check("d2_restart_present", bus2.present, 8'hFF);

        // dut2: third descend invades; position freezes; start zeroes score.
        ticks(1, 291);
        check("d2_inv_invaded", bus2.invaded, 1);
        check("d2_inv_y", bus2.masterPosY, 108);
        check("d2_inv_x", bus2.masterPosX, 400);
        check("d2_inv_present", bus2.present, 8'hFF);
        ticks(1, 5);
        check("d2_frozen_x", bus2.masterPosX, 400);
        check("d2_frozen_y", bus2.masterPosY, 108);
        pulse_start(1);
        check("d2_inv_restart_score", bus2.score, 0);
        check("d2_inv_restart_invaded", bus2.invaded, 0);
        check("d2_inv_restart_y", bus2.masterPosY, 60);

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
